// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encoding includes the checksum states used when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 2;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        CK_HI = 3'd5,
        CK_LO = 3'd6
    } state_t;

    // Instructions arrive high byte first.
    function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] hi,
                                                    input logic [BYTE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Two-byte capture register for the loader; with IMEM_LOADER_CHECKSUM_EN it also keeps
// the running mod-2^16 sum of written words and compares it with the received checksum.
module imem_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              cap_hi,
    input  logic              cap_lo,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [DATA_W-1:0] word
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic              ck_match
`endif
);

    logic [BYTE_W-1:0] hi_r;
    logic [DATA_W-1:0] word_r;
    logic [DATA_W-1:0] next_word_s;

    assign next_word_s = pack_word(hi_r, byte_in);
    assign word        = word_r;

    // High byte held until the low byte completes the word; word only changes on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r   <= {BYTE_W{1'b0}};
            word_r <= {DATA_W{1'b0}};
        end else begin
            if (clear) begin
                hi_r <= {BYTE_W{1'b0}};
            end else if (cap_hi) begin
                hi_r <= byte_in;
            end
            if (cap_lo) begin
                word_r <= next_word_s;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_r;

    // Running sum of every word written during the current load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= {DATA_W{1'b0}};
        end else if (clear) begin
            sum_r <= {DATA_W{1'b0}};
        end else if (cap_lo) begin
            sum_r <= sum_r + next_word_s;
        end
    end

    // During CK_LO hi_r holds the checksum high byte and byte_in the low byte.
    assign ck_match = (next_word_s == sum_r);
`endif

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs byte pairs into words and writes
// them at consecutive addresses from 0. Optional checksum phase: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_words,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE_W   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_W  = {ADDR_W{1'b0}};

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] nwords_r;
    logic              we_r;
    logic              done_r;
    logic              err_r;

    logic              xfer_s;
    logic              ready_s;
    logic              accept_s;
    logic              cap_hi_s;
    logic              cap_lo_s;
    logic              last_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic              ck_match_s;
`endif

    // Byte acceptance is a pure decode of the current state.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            HI, LO:       ready_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CK_HI, CK_LO: ready_s = 1'b1;
`endif
            default:      ready_s = 1'b0;
        endcase
    end

    assign xfer_s   = byte_valid & ready_s;
    assign accept_s = (state_r == IDLE) & start & (num_words <= DEPTH_W);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign cap_hi_s = xfer_s & ((state_r == HI) | (state_r == CK_HI));
`else
    assign cap_hi_s = xfer_s & (state_r == HI);
`endif
    assign cap_lo_s = xfer_s & (state_r == LO);
    assign last_s   = (addr_r == (nwords_r - ONE_W));

    imem_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept_s),
        .cap_hi   (cap_hi_s),
        .cap_lo   (cap_lo_s),
        .byte_in  (byte_in),
        .word     (mem_wdata)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .ck_match (ck_match_s)
`endif
    );

    // Load sequencer: start checks, word counting, write strobe and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            addr_r   <= ZERO_W;
            nwords_r <= ZERO_W;
            we_r     <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            we_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    addr_r <= ZERO_W;
                    if (start) begin
                        if (num_words == ZERO_W) begin
                            done_r  <= 1'b0;
                            err_r   <= 1'b0;
                            state_r <= DONE;
                        end else if (num_words > DEPTH_W) begin
                            err_r <= 1'b1;
                        end else begin
                            done_r   <= 1'b0;
                            err_r    <= 1'b0;
                            nwords_r <= num_words;
                            state_r  <= HI;
                        end
                    end
                end
                HI: begin
                    if (xfer_s) begin
                        state_r <= LO;
                    end
                end
                LO: begin
                    if (xfer_s) begin
                        we_r    <= 1'b1;
                        state_r <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_s) begin
                        addr_r <= ZERO_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_r <= CK_HI;
`else
                        state_r <= DONE;
`endif
                    end else begin
                        addr_r  <= addr_r + ONE_W;
                        state_r <= HI;
                    end
                end
                DONE: begin
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CK_HI: begin
                    if (xfer_s) begin
                        state_r <= CK_LO;
                    end
                end
                CK_LO: begin
                    if (xfer_s) begin
                        if (ck_match_s) begin
                            state_r <= DONE;
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= IDLE;
                        end
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign byte_ready = ready_s;
    assign busy       = (state_r != IDLE);
    assign mem_we     = we_r;
    assign mem_addr   = addr_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads against a queue-based write model.
module tb_imem_loader;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_words = 16'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          first_cyc = 0;
    int          last_we_cyc = 0;
    logic [7:0]  stim[$];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic [15:0] obs_addr[$];
    logic [15:0] obs_data[$];
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Every-cycle compare of the write port against the expected-write queue.
    initial begin : compare
        logic prev_we;
        logic [15:0] ea;
        logic [15:0] ed;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_we) begin
                    chk("ready_during_write", {31'd0, byte_ready}, 32'd0);
                    chk("we_one_cycle", {31'd0, prev_we}, 32'd0);
                    if (exp_addr.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write actual=%0h@%0h expected=none", mem_wdata, mem_addr);
                    end else begin
                        ea = exp_addr.pop_front();
                        ed = exp_data.pop_front();
                        chk("wr_addr", {16'd0, mem_addr}, {16'd0, ea});
                        chk("wr_data", {16'd0, mem_wdata}, {16'd0, ed});
                    end
                    obs_addr.push_back(mem_addr);
                    obs_data.push_back(mem_wdata);
                    last_we_cyc = cyc;
                end
                if (!busy) begin
                    chk("idle_addr_zero", {16'd0, mem_addr}, 32'd0);
                    chk("idle_not_ready", {31'd0, byte_ready}, 32'd0);
                end
                prev_we = mem_we;
            end else begin
                prev_we = 1'b0;
            end
        end
    end

    // Model: a valid load writes {b[2i],b[2i+1]} at address i; flags follow the start rules.
    task automatic run_load(input int n, input logic [3:0] pat, input bit corrupt, input bit poke);
        int k;
        int idx;
        int guard;
        logic [15:0] w;
        logic [15:0] sum;
        obs_addr.delete();
        obs_data.delete();
        sum = 16'd0;
        if (n == 0) begin
            m_done = 1'b1;
            m_err  = 1'b0;
        end else if (n > DEPTH) begin
            m_err = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                w = {stim[2*i], stim[2*i+1]};
                exp_addr.push_back(16'(i));
                exp_data.push_back(w);
                sum = sum + w;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            stim.push_back(sum[15:8]);
            stim.push_back(sum[7:0] ^ {7'd0, corrupt});
            m_done = !corrupt;
            m_err  = corrupt;
`else
            m_done = 1'b1;
            m_err  = 1'b0;
`endif
        end
        @(negedge clk);
        start = 1'b1;
        num_words = 16'(n);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        idx = 0;
        guard = 0;
        while (idx < stim.size() && guard < 2000) begin
            byte_valid = pat[3 - (k % 4)];
            byte_in = stim[idx];
            if (poke && k == 0) begin
                start = 1'b1;
                num_words = 16'd7;
            end
            if (byte_valid && byte_ready) begin
                if (idx == 0) first_cyc = cyc;
                idx++;
            end
            k++;
            guard++;
            @(negedge clk);
            start = 1'b0;
        end
        byte_valid = 1'b0;
        if (guard >= 2000) begin
            total++;
            bad++;
            $display("FAIL stream_timeout actual=%0d expected=%0d bytes", idx, stim.size());
        end
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("busy_after_load", {31'd0, busy}, 32'd0);
        chk("done_flag", {31'd0, done}, {31'd0, m_done});
        chk("err_flag", {31'd0, err}, {31'd0, m_err});
        chk("writes_left", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        stim.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {25'd0, byte_ready, mem_we, busy, done, err, |mem_addr, |mem_wdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-rate three-word load.
        stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        run_load(3, 4'b1111, 1'b0, 1'b0);
        chk("lit_w0", {16'd0, obs_data[0]}, 32'h1234);
        chk("lit_w1_addr", {16'd0, obs_addr[1]}, 32'd1);
        chk("lit_w2", {16'd0, obs_data[2]}, 32'h9ABC);
        chk("lit_w2_addr", {16'd0, obs_addr[2]}, 32'd2);
        chk("first_byte_to_last_write", 32'(last_we_cyc - first_cyc + 1), 32'd9);

        // Same load under 1,0,0,1 backpressure.
        stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        run_load(3, 4'b1001, 1'b0, 1'b0);
        chk("bp_count", 32'(obs_data.size()), 32'd3);
        chk("bp_w1", {16'd0, obs_data[1]}, 32'h5678);

        // Zero-length load, then oversize rejection.
        run_load(0, 4'b1111, 1'b0, 1'b0);
        chk("zero_no_write", 32'(obs_data.size()), 32'd0);
        run_load(33, 4'b1111, 1'b0, 1'b0);
        chk("oversize_no_write", 32'(obs_data.size()), 32'd0);

        // Full-depth load.
        for (int i = 0; i < 2 * DEPTH; i++) stim.push_back(8'(i * 7 + 3));
        run_load(DEPTH, 4'b1111, 1'b0, 1'b0);
        chk("depth_last_addr", {16'd0, obs_addr[DEPTH-1]}, 32'd31);
        chk("depth_count", 32'(obs_data.size()), 32'd32);

        // Reset while waiting for the low byte.
        @(negedge clk);
        start = 1'b1;
        num_words = 16'd1;
        @(negedge clk);
        start = 1'b0;
        byte_valid = 1'b1;
        byte_in = 8'hAA;
        @(negedge clk);
        byte_valid = 1'b0;
        chk("in_lo_ready", {31'd0, byte_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midload_reset_outputs", {25'd0, byte_ready, mem_we, busy, done, err, |mem_addr, |mem_wdata}, 32'd0);
        m_done = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stim = '{8'h5A, 8'hC3};
        run_load(1, 4'b1111, 1'b0, 1'b0);
        chk("post_reset_addr", {16'd0, obs_addr[0]}, 32'd0);
        chk("post_reset_data", {16'd0, obs_data[0]}, 32'h5AC3);

        // start pulsed while waiting in HI is ignored.
        stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(2, 4'b0111, 1'b0, 1'b1);
        chk("poke_count", 32'(obs_data.size()), 32'd2);
        chk("poke_w1", {16'd0, obs_data[1]}, 32'hBEEF);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 0x0001 + 0xFFFF wraps to 0x0000: bytes 00 00 pass, 00 01 fail.
        stim = '{8'h00, 8'h01, 8'hFF, 8'hFF};
        run_load(2, 4'b1111, 1'b0, 1'b0);
        chk("ck_good_done", {31'd0, done}, 32'd1);
        stim = '{8'h00, 8'h01, 8'hFF, 8'hFF};
        run_load(2, 4'b1111, 1'b1, 1'b0);
        chk("ck_bad_err", {31'd0, err}, 32'd1);
        chk("ck_bad_done", {31'd0, done}, 32'd0);
        chk("ck_bad_writes", 32'(obs_data.size()), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
